// File: rtl/ucode_seq.sv
// Microcode sequencer between decode (DE1) and rename (RN0): expands one held uinstr into 1..MAX_UOPS uops.
// Optional macro UCODE_SEQ_PERF_EN adds saturating drain/stall/uop performance counters.

package instr_decode;
  typedef struct packed {
    logic       valid;
    logic [5:0] rob_id;
  } t_nuke_pkt;

  typedef struct packed {
    logic [7:0]  uop;
    logic [3:0]  num_uops;
    logic [15:0] imm;
  } t_uinstr;

  function automatic logic [3:0] f_uc_num_uops(input t_uinstr ui);
    return ui.num_uops;
  endfunction

  function automatic logic f_uc_serializing(input logic [7:0] uop);
    return uop[7];
  endfunction
endpackage

module ucode_seq
  import instr_decode::*;
#(
  parameter int MAX_UOPS = 4,
  parameter int IDX_W    = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  t_nuke_pkt        nuke_rb1,
  input  logic             valid_de1,
  input  t_uinstr          uinstr_de1,
  output logic             ucode_ready_uc0,
  input  logic             rob_empty_rb,
  input  logic             rename_ready_rn0,
  output logic             valid_uc0,
  output t_uinstr          uinstr_uc0,
  output logic [IDX_W-1:0] uc_idx_uc0,
  output logic             uc_last_uc0
`ifdef UCODE_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_drain_cyc,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_uops
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SEQ   = 2'd2
  } t_state;

  t_state           r_state;
  t_state           w_state_nxt;
  t_state           w_fill_state;
  t_uinstr          r_hold;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_new_last;
  logic [3:0]       w_raw_n;
  logic             w_load;
  logic             w_last;
  logic             w_issue;
  logic             w_nuke;
  logic             w_unused_nuke;

  assign w_nuke        = nuke_rb1.valid;
  assign w_unused_nuke = ^nuke_rb1.rob_id;
  assign w_raw_n       = f_uc_num_uops(uinstr_de1);

  // Store the last step index rather than the count so the compare is IDX_W wide.
  always_comb begin
    w_new_last = '0;
    if (w_raw_n == 4'd0) begin
      w_new_last = '0;
    end else if (int'(w_raw_n) >= MAX_UOPS) begin
      w_new_last = IDX_W'(MAX_UOPS - 1);
    end else begin
      w_new_last = IDX_W'(w_raw_n - 4'd1);
    end
  end

  assign w_fill_state = (f_uc_serializing(uinstr_de1.uop) && !rob_empty_rb) ? DRAIN : SEQ;

  assign w_last          = (r_state != IDLE) && (r_idx == r_last_idx);
  assign valid_uc0       = (r_state == SEQ) && !w_nuke;
  assign w_issue         = valid_uc0 && rename_ready_rn0;
  assign ucode_ready_uc0 = !reset && !w_nuke &&
                           ((r_state == IDLE) || ((r_state == SEQ) && w_last && rename_ready_rn0));
  assign uinstr_uc0      = r_hold;
  assign uc_idx_uc0      = r_idx;
  assign uc_last_uc0     = w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    if (w_nuke) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (valid_de1) begin
            w_load      = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = w_fill_state;
          end
        end
        DRAIN: begin
          if (rob_empty_rb) begin
            w_state_nxt = SEQ;
          end
        end
        SEQ: begin
          if (rename_ready_rn0) begin
            if (w_last) begin
              w_idx_nxt = '0;
              if (valid_de1) begin
                w_load      = 1'b1;
                w_state_nxt = w_fill_state;
              end else begin
                w_state_nxt = IDLE;
              end
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_hold     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_hold     <= uinstr_de1;
        r_last_idx <= w_new_last;
      end
    end
  end

`ifdef UCODE_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_drain_cyc <= '0;
      perf_stall_cyc <= '0;
      perf_uops      <= '0;
    end else begin
      if ((r_state == DRAIN) && (perf_drain_cyc != '1)) perf_drain_cyc <= perf_drain_cyc + 32'd1;
      if (valid_uc0 && !rename_ready_rn0 && (perf_stall_cyc != '1)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (w_issue && (perf_uops != '1)) perf_uops <= perf_uops + 32'd1;
    end
  end
`endif

`ifdef ASSERT
  a_pop_qualified: assert property (@(posedge clk) disable iff (reset) valid_de1 |-> ucode_ready_uc0);
  a_idx_range:     assert property (@(posedge clk) disable iff (reset) int'(r_idx) <= MAX_UOPS - 1);
`endif

endmodule
